// File: rtl/md_unit_if.sv
// Purpose: groups the md_unit issue inputs and HI/LO result outputs into one bundle.
// Latency: none; this file holds wiring only.
// Backpressure: none; the issuer stalls on busy, and the HI/LO consumer qualifies data with hilo_we.
// Ports:
//   start/op/opa/opb : launch request and operands, driven by the issuer (master).
//   cancel           : abort request from exception/flush logic (master).
//   busy/hilo_we/hi_o/lo_o : status and result, driven by md_unit (slave).
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cancel;
  logic             busy;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start, op, opa, opb, cancel,
    input  busy, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  start, op, opa, opb, cancel,
    output busy, hilo_we, hi_o, lo_o
  );
endinterface

// File: rtl/md_unit.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU unit that produces the HI/LO register write.
// Latency: WIDTH+1 cycles from an accepted start to hilo_we; divide-by-zero takes 1 cycle.
// Backpressure: busy stays high while an operation runs, and starts that arrive while busy are dropped.
// Ports:
//   clk, rst : clock and synchronous active-high reset.
//   bus      : md_unit_if slave carrying start/op/opa/opb/cancel in and busy/hilo_we/hi_o/lo_o out.
module md_unit #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  md_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_res;   // signs differ: negate product / quotient
  logic             neg_rem;   // dividend negative: negate remainder
  logic [WIDTH-1:0] opnd;      // multiplicand (multiply) or divisor (divide) magnitude
  logic [WIDTH-1:0] acc_hi;    // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend bits becoming quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             accept;
  logic             div_zero;
  logic             last;
  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  // Issue-side decode; op[0]=1 selects the unsigned variants.
  assign accept   = (state == IDLE) & bus.start & ~bus.cancel;
  assign div_zero = bus.op[1] & (bus.opb == '0);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign sgn_a    = ~bus.op[0] & bus.opa[WIDTH-1];
  assign sgn_b    = ~bus.op[0] & bus.opb[WIDTH-1];
  assign mag_a    = sgn_a ? -bus.opa : bus.opa;
  assign mag_b    = sgn_b ? -bus.opb : bus.opb;

  // One radix-2 step, plus the sign-corrected result used when entering DONE.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Shifted partial remainder; its carry-out is acc_hi's MSB, so a set MSB
    // means the shifted value already exceeds any WIDTH-bit divisor.
    rem_sh  = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    div_ge  = acc_hi[WIDTH-1] | (rem_sh >= opnd);
    if (is_div) begin
      step_hi = div_ge ? (rem_sh - opnd) : rem_sh;
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
    prod_fix = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
    if (is_div) begin
      fin_hi = neg_rem ? -step_hi : step_hi;
      fin_lo = neg_res ? -step_lo : step_lo;
    end else begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            is_div  <= bus.op[1];
            neg_res <= sgn_a ^ sgn_b;
            neg_rem <= sgn_a;
            acc_hi  <= '0;
            opnd    <= bus.op[1] ? mag_b : mag_a;
            acc_lo  <= bus.op[1] ? mag_a : mag_b;
            if (div_zero) begin
              hi_q <= bus.opa;
              lo_q <= '1;
            end
          end
        end
        CALC: begin
          if (!bus.cancel) begin
            cnt    <= cnt + CW'(1);
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (last) begin
              hi_q <= fin_hi;
              lo_q <= fin_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.hilo_we = (state == DONE) & ~bus.cancel;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Purpose: self-checking bench for md_unit against an arithmetic reference model.
// Latency: checks every cycle of each operation for busy, hilo_we and held hi/lo values.
// Backpressure: issues back-to-back, and also exercises cancel, reset and start-while-busy.
module tb_md_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  md_unit_if #(.WIDTH(W)) bus();

  md_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] held_hi = '0;
  logic [W-1:0] held_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (op)
      2'd0: r = 64'(sa * sb);
      2'd1: r = ua * ub;
      default: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFFFFFF};
        end else if (op == 2'd2) begin
          sq = sa / sb;
          sr = sa % sb;
          uq = 64'(sq);
          ur = 64'(sr);
          r  = {ur[31:0], uq[31:0]};
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Caller is just past a negedge, in the cycle T where start is presented.
  // cancel_at/restart_at/rst_at give the cycle offset (from T) where that input
  // is raised for one cycle; 0 disables it.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cancel_at, input int restart_at,
                        input int rst_at);
    logic [63:0] res;
    int          lat;
    int          stop_at;
    bit          aborted;
    bit          we_exp;
    bit          busy_exp;
    res     = ref_md(op, a, b);
    lat     = (op[1] && b == 32'd0) ? 1 : W + 1;
    stop_at = lat + 1;
    if (cancel_at > 0 && cancel_at < stop_at) stop_at = cancel_at + 1;
    if (rst_at > 0 && rst_at < stop_at) stop_at = rst_at + 1;

    bus.start  = 1'b1;
    bus.op     = op;
    bus.opa    = a;
    bus.opb    = b;
    bus.cancel = 1'b0;

    for (int c = 1; c <= stop_at; c++) begin
      @(negedge clk);
      bus.start  = (c == restart_at);
      bus.op     = 2'($urandom);
      bus.opa    = $urandom;
      bus.opb    = $urandom;
      bus.cancel = (c == cancel_at);
      rst        = (c == rst_at);
      #1;
      aborted = (cancel_at > 0 && c > cancel_at) || (rst_at > 0 && c > rst_at);
      if (rst_at > 0 && c == rst_at + 1) begin
        held_hi = '0;
        held_lo = '0;
      end
      if (!aborted && c == lat) begin
        held_hi = res[63:32];
        held_lo = res[31:0];
      end
      busy_exp = !aborted && (c <= lat);
      we_exp   = !aborted && (c == lat) && (c != cancel_at);
      check({name, ".busy"},    64'(bus.busy),    64'(busy_exp));
      check({name, ".hilo_we"}, 64'(bus.hilo_we), 64'(we_exp));
      check({name, ".hi"},      64'(bus.hi_o),    64'(held_hi));
      check({name, ".lo"},      64'(bus.lo_o),    64'(held_lo));
    end
    bus.cancel = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h80000000;
      1:       v = 32'hFFFFFFFF;
      2:       v = 32'h00000000;
      3:       v = 32'h00000001;
      4:       v = 32'($urandom_range(0, 255));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          rcancel, rrestart, rlat;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'd0;
    bus.opa    = '0;
    bus.opb    = '0;
    bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset.busy",    64'(bus.busy),    64'd0);
    check("reset.hilo_we", 64'(bus.hilo_we), 64'd0);
    check("reset.hi",      64'(bus.hi_o),    64'd0);
    check("reset.lo",      64'(bus.lo_o),    64'd0);
    @(negedge clk);
    rst = 1'b0;

    // start together with cancel is refused.
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = 2'd1;
    bus.opa    = 32'd5;
    bus.opb    = 32'd6;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    #1;
    check("start_cancel.busy",    64'(bus.busy),    64'd0);
    check("start_cancel.hilo_we", 64'(bus.hilo_we), 64'd0);
    @(negedge clk);

    run_op("divu_100_7",   2'd3, 32'd100,        32'd7,          0, 0, 0);
    run_op("div_m7_2",     2'd2, 32'hFFFFFFF9,   32'd2,          0, 0, 0);
    run_op("div_ovf",      2'd2, 32'h80000000,   32'hFFFFFFFF,   0, 0, 0);
    run_op("mult_m1_2",    2'd0, 32'hFFFFFFFF,   32'd2,          0, 0, 0);
    run_op("multu_m1_2",   2'd1, 32'hFFFFFFFF,   32'd2,          0, 0, 0);
    run_op("divu_by0",     2'd3, 32'h00001234,   32'd0,          0, 0, 0);
    run_op("div_by0",      2'd2, 32'hFFFF0000,   32'd0,          0, 0, 0);
    run_op("multu_cancel", 2'd1, 32'h12345678,   32'h9ABCDEF0,  10, 0, 0);
    run_op("divu_9_3",     2'd3, 32'd9,          32'd3,          0, 0, 0);
    run_op("div_rst",      2'd2, 32'h7FFFFFFF,   32'd3,          0, 0, 5);
    run_op("mult_restart", 2'd0, 32'h80000000,   32'h80000000,   0, 3, 0);
    run_op("mult_done_cancel", 2'd0, 32'd7,      32'hFFFFFFFD,  33, 0, 0);

    for (int i = 0; i < 30; i++) begin
      rop      = 2'($urandom_range(0, 3));
      ra       = pick_operand();
      rb       = pick_operand();
      rlat     = (rop[1] && rb == 32'd0) ? 1 : W + 1;
      rcancel  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, rlat) : 0;
      rrestart = (rlat > 5 && $urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 0;
      run_op("random", rop, ra, rb, rcancel, rrestart, 0);
    end

    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("final.busy",    64'(bus.busy),    64'd0);
    check("final.hilo_we", 64'(bus.hilo_we), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
